// File: rtl/fifo_wr_packer.sv
// -----------------------------------------------------------------------------
// fifo_wr_packer
//
// Packs P_RATIO narrow input beats (D_WIDTH bits each) into one wide word and
// writes it into a FIFO living in the same clock domain. Lane 0 is the first
// beat of a word and sits at the LSBs. A word is emitted early when the beat
// carries in_last_i or when flush_i is pulsed with at least one beat held.
// Any lanes not filled by the time a word completes are zero.
//
// Handshake (input side): a beat transfers on a rising edge of wr_clk_i when
// in_valid_i & in_ready_o are both high; otherwise nothing changes. The
// FIFO side is a write-enable interface: a word is written on an edge where
// fifo_en_o & ~fifo_full_i; while fifo_full_i is high the word is held.
//
// Ports
//   wr_clk_i     in   1              write-domain clock (rising edge)
//   wr_rst_n_i   in   1              asynchronous active-low reset
//   in_valid_i   in   1              input beat valid
//   in_ready_o   out  1              input beat ready
//   in_data_i    in   D_WIDTH        input beat data
//   in_last_i    in   1              final beat of frame (qualified by accept)
//   flush_i      in   1              single-cycle request to emit partial word
//   fifo_en_o    out  1              FIFO write enable
//   fifo_data_o  out  D_WIDTH*P_RATIO FIFO write data
//   fifo_full_i  in   1              FIFO full flag
//   word_cnt_o   out  32             words written to the FIFO (wraps)
//   frame_cnt_o  out  32             accepted in_last_i beats (wraps)
// -----------------------------------------------------------------------------
module fifo_wr_packer #(
  parameter int D_WIDTH = 8,
  parameter int P_RATIO = 8
) (
  input  logic                         wr_clk_i,
  input  logic                         wr_rst_n_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [D_WIDTH-1:0]           in_data_i,
  input  logic                         in_last_i,
  input  logic                         flush_i,
  output logic                         fifo_en_o,
  output logic [D_WIDTH*P_RATIO-1:0]   fifo_data_o,
  input  logic                         fifo_full_i,
  output logic [31:0]                  word_cnt_o,
  output logic [31:0]                  frame_cnt_o
);

  localparam int L_W = $clog2(P_RATIO);
  localparam int F_W = D_WIDTH * P_RATIO;
  localparam logic [L_W-1:0] LAST_LANE = L_W'(P_RATIO - 1);

  // State
  logic [L_W-1:0] lane_cnt_q, lane_cnt_d;
  logic [F_W-1:0] acc_q, acc_d;
  logic [F_W-1:0] out_q, out_d;
  logic           out_pend_q, out_pend_d;
  logic [31:0]    word_cnt_q, word_cnt_d;
  logic [31:0]    frame_cnt_q, frame_cnt_d;

  // Combinational helpers
  logic           in_ready;
  logic           accept;
  logic           fifo_write;
  logic           beat_done;
  logic           flush_done;
  logic           complete;
  logic [F_W-1:0] acc_merged;
  logic [F_W-1:0] word;

  always_comb begin
    // The output slot can take a new word if it is empty or drains this edge.
    in_ready   = ~out_pend_q | ~fifo_full_i;
    accept     = in_valid_i & in_ready;
    fifo_write = out_pend_q & ~fifo_full_i;

    // Accumulator contents including a beat landing this cycle.
    acc_merged = acc_q;
    for (int k = 0; k < P_RATIO; k++) begin
      if (accept && (lane_cnt_q == L_W'(k))) begin
        acc_merged[k*D_WIDTH +: D_WIDTH] = in_data_i;
      end
    end

    // Keep only lanes that actually hold a beat; everything above is zero.
    word = '0;
    for (int k = 0; k < P_RATIO; k++) begin
      if ((L_W'(k) < lane_cnt_q) || (accept && (L_W'(k) == lane_cnt_q))) begin
        word[k*D_WIDTH +: D_WIDTH] = acc_merged[k*D_WIDTH +: D_WIDTH];
      end
    end

    beat_done = accept & ((lane_cnt_q == LAST_LANE) | in_last_i);
    // A flush needs something to emit (held lanes or a beat this cycle) and a
    // free output slot. A flush arriving while the slot is blocked by a full
    // FIFO is dropped; the partial word then waits for more beats.
    flush_done = flush_i & in_ready & ((lane_cnt_q != '0) | accept);
    // beat_done and flush_done in the same cycle still produce one word.
    complete   = beat_done | flush_done;

    // Next-state defaults
    lane_cnt_d  = lane_cnt_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_pend_d  = out_pend_q;
    word_cnt_d  = word_cnt_q;
    frame_cnt_d = frame_cnt_q;

    if (complete) begin
      lane_cnt_d = '0;
      acc_d      = '0;
    end else if (accept) begin
      lane_cnt_d = lane_cnt_q + L_W'(1);
      acc_d      = acc_merged;
    end

    // A completing word can only arrive when the slot is free or draining,
    // so overwriting out_q here never loses a pending word.
    if (complete) begin
      out_d      = word;
      out_pend_d = 1'b1;
    end else if (fifo_write) begin
      out_pend_d = 1'b0;
    end

    if (fifo_write) begin
      word_cnt_d = word_cnt_q + 32'd1;
    end
    if (accept && in_last_i) begin
      frame_cnt_d = frame_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge wr_clk_i or negedge wr_rst_n_i) begin
    if (!wr_rst_n_i) begin
      lane_cnt_q  <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_pend_q  <= 1'b0;
      word_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      lane_cnt_q  <= lane_cnt_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_pend_q  <= out_pend_d;
      word_cnt_q  <= word_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign in_ready_o  = in_ready;
  assign fifo_en_o   = out_pend_q;
  assign fifo_data_o = out_q;
  assign word_cnt_o  = word_cnt_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_fifo_wr_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_packer
//
// Directed bench for fifo_wr_packer with D_WIDTH=8, P_RATIO=4. Stimulus pushes
// hand-computed FIFO words into exp_q; a monitor pops and compares on every
// FIFO write (fifo_en_o & ~fifo_full_i). Inputs change 1ns after a rising
// edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fifo_wr_packer;

  localparam int DW = 8;
  localparam int PR = 4;
  localparam int FW = DW * PR;

  // Clock / reset
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          flush;
  logic          fifo_en;
  logic [FW-1:0] fifo_data;
  logic          fifo_full;
  logic [31:0]   word_cnt;
  logic [31:0]   frame_cnt;

  fifo_wr_packer #(.D_WIDTH(DW), .P_RATIO(PR)) dut (
    .wr_clk_i    (clk),
    .wr_rst_n_i  (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .flush_i     (flush),
    .fifo_en_o   (fifo_en),
    .fifo_data_o (fifo_data),
    .fifo_full_i (fifo_full),
    .word_cnt_o  (word_cnt),
    .frame_cnt_o (frame_cnt)
  );

  // Scoreboard state
  logic [FW-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_err  = 0;
  int stalls = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every FIFO write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && fifo_en && !fifo_full) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got 0x%08h expected no write at %0t", fifo_data, $time);
      end else begin
        chk("fifo_word", fifo_data, exp_q.pop_front());
      end
    end
  end

  // Driver tasks. All of them start and end 1ns after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic last, input logic fl);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    flush    = fl;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      stalls++;
      guard++;
      tick();
      @(negedge clk);
    end
    if (!in_ready) chk("beat_accept_timeout", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    flush    = 1'b0;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    flush     = 1'b0;
    fifo_full = 1'b0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #2;
    // Reset state
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("rst_fifo_en",   {31'd0, fifo_en},  32'd0);
    chk("rst_fifo_data", fifo_data,         32'd0);
    chk("rst_word_cnt",  word_cnt,          32'd0);
    chk("rst_frame_cnt", frame_cnt,         32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Four beats back-to-back form one full word
    exp_q.push_back(32'h44332211);
    beat(8'h11, 1'b0, 1'b0);
    beat(8'h22, 1'b0, 1'b0);
    beat(8'h33, 1'b0, 1'b0);
    beat(8'h44, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_word_en",   {31'd0, fifo_en}, 32'd1);
    chk("full_word_data", fifo_data,        32'h44332211);
    tick();
    @(negedge clk);
    chk("full_word_en_drop", {31'd0, fifo_en}, 32'd0);
    chk("full_word_cnt",     word_cnt,         32'd1);
    tick();

    // Short frame ended by in_last_i
    exp_q.push_back(32'h0000BBAA);
    beat(8'hAA, 1'b0, 1'b0);
    beat(8'hBB, 1'b1, 1'b0);
    @(negedge clk);
    chk("last_word_data", fifo_data, 32'h0000BBAA);
    tick();
    @(negedge clk);
    chk("last_frame_cnt", frame_cnt, 32'd1);
    chk("last_word_cnt",  word_cnt,  32'd2);
    tick();

    // Full FIFO back-pressure; word starts at lane 0 after the short frame
    fifo_full = 1'b1;
    exp_q.push_back(32'hD4D3D2D1);
    beat(8'hD1, 1'b0, 1'b0);
    beat(8'hD2, 1'b0, 1'b0);
    beat(8'hD3, 1'b0, 1'b0);
    beat(8'hD4, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_hold_en",    {31'd0, fifo_en},  32'd1);
      chk("full_hold_data",  fifo_data,         32'hD4D3D2D1);
      chk("full_hold_ready", {31'd0, in_ready}, 32'd0);
      chk("full_hold_cnt",   word_cnt,          32'd2);
      tick();
    end
    fifo_full = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("full_release_cnt", word_cnt,         32'd3);
    chk("full_release_en",  {31'd0, fifo_en}, 32'd0);
    tick();

    // Flush of a single held beat
    exp_q.push_back(32'h00000055);
    beat(8'h55, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_word_data", fifo_data, 32'h00000055);
    tick();
    // Flush with nothing held: no write
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_empty_en", {31'd0, fifo_en}, 32'd0);
      tick();
    end
    chk("flush_word_cnt", word_cnt, 32'd4);

    // Flush on the same beat that fills lane 3: one word only
    exp_q.push_back(32'h69686766);
    beat(8'h66, 1'b0, 1'b0);
    beat(8'h67, 1'b0, 1'b0);
    beat(8'h68, 1'b0, 1'b0);
    beat(8'h69, 1'b0, 1'b1);
    // in_last_i on lane 3: one word only
    exp_q.push_back(32'h74737271);
    beat(8'h71, 1'b0, 1'b0);
    beat(8'h72, 1'b0, 1'b0);
    beat(8'h73, 1'b0, 1'b0);
    beat(8'h74, 1'b1, 1'b0);
    // Flush together with a beat into an empty accumulator
    exp_q.push_back(32'h00000081);
    beat(8'h81, 1'b0, 1'b1);
    repeat (3) tick();
    @(negedge clk);
    chk("edge_word_cnt",  word_cnt,  32'd7);
    chk("edge_frame_cnt", frame_cnt, 32'd2);
    tick();

    // 16 beats streamed continuously
    exp_q.push_back(32'h13121110);
    exp_q.push_back(32'h17161514);
    exp_q.push_back(32'h1B1A1918);
    exp_q.push_back(32'h1F1E1D1C);
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      beat(8'(8'h10 + i), 1'b0, 1'b0);
    end
    chk("stream_stalls", stalls, 32'd0);
    repeat (2) tick();
    @(negedge clk);
    chk("stream_word_cnt", word_cnt, 32'd11);
    tick();

    // Reset in the middle of a partial word
    beat(8'hE1, 1'b0, 1'b0);
    beat(8'hE2, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_en",        {31'd0, fifo_en},  32'd0);
    chk("midrst_data",      fifo_data,         32'd0);
    chk("midrst_ready",     {31'd0, in_ready}, 32'd1);
    chk("midrst_word_cnt",  word_cnt,          32'd0);
    chk("midrst_frame_cnt", frame_cnt,         32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postrst_no_write", {31'd0, fifo_en}, 32'd0);
      tick();
    end
    exp_q.push_back(32'h04030201);
    beat(8'h01, 1'b0, 1'b0);
    beat(8'h02, 1'b0, 1'b0);
    beat(8'h03, 1'b0, 1'b0);
    beat(8'h04, 1'b0, 1'b0);
    @(negedge clk);
    chk("postrst_word_data", fifo_data, 32'h04030201);
    tick();
    @(negedge clk);
    chk("postrst_word_cnt", word_cnt, 32'd1);
    tick();

    repeat (3) tick();
    chk("exp_q_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_packer.md
FIFO_WR_PACKER -- requirements
Module: fifo_wr_packer

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8: input beat width in bits.
REQ-002 SHALL have parameter P_RATIO, default 8, power of two >= 2: beats packed per FIFO entry.
REQ-003 SHALL have port wr_clk_i  input  1  write-domain clock; all logic on its rising edge.
REQ-004 SHALL have port wr_rst_n_i  input  1  reset, asynchronous, active-low; clock wr_clk_i.
REQ-005 SHALL have port in_valid_i  input  1  input beat valid.
REQ-006 SHALL have port in_ready_o  output  1  input beat ready.
REQ-007 SHALL have port in_data_i  input  D_WIDTH  input beat data.
REQ-008 SHALL have port in_last_i  input  1  final beat of frame; qualified by accepted beat.
REQ-009 SHALL have port flush_i  input  1  force out a partial word; single-cycle pulse.
REQ-010 SHALL have port fifo_en_o  output  1  FIFO write enable.
REQ-011 SHALL have port fifo_data_o  output  D_WIDTH*P_RATIO  FIFO write data.
REQ-012 SHALL have port fifo_full_i  input  1  FIFO full flag, same clock domain.
REQ-013 SHALL have port word_cnt_o  output  32  count of words written to FIFO, wraps.
REQ-014 SHALL have port frame_cnt_o  output  32  count of accepted in_last_i beats, wraps.

Function
REQ-015 SHALL accept a beat in any cycle with in_valid_i & in_ready_o, else SHALL leave all state unchanged for that beat.
REQ-016 SHALL drive in_ready_o = ~out_pend | ~fifo_full_i; out_pend is the registered output-slot-occupied flag.
REQ-017 SHALL write an accepted beat into lane lane_cnt of the accumulator; lane 0 at LSBs, lane k at bits [k*D_WIDTH +: D_WIDTH].
REQ-018 SHALL use lane_cnt width $clog2(P_RATIO); increment on each accepted non-completing beat.
REQ-019 SHALL complete a word when an accepted beat has lane_cnt==P_RATIO-1 or in_last_i=1.
REQ-020 SHALL complete a word when flush_i=1 and the accumulator holds >=1 beat, including a beat accepted in the same cycle.
REQ-021 SHALL treat flush_i with an empty accumulator and no accepted beat as a no-op.
REQ-022 SHALL zero all unfilled lanes of a completed word.
REQ-023 SHALL copy a completed word to the output register on the completing edge, set out_pend=1, and clear lane_cnt and the accumulator.
REQ-024 SHALL drive fifo_en_o = out_pend and fifo_data_o = output register: completing beat at edge N gives fifo_en_o=1 in cycle N+1.
REQ-025 SHALL count a FIFO write when fifo_en_o & ~fifo_full_i, and SHALL clear out_pend on that edge unless a new word completes on the same edge.
REQ-026 SHALL hold fifo_en_o and fifo_data_o stable while fifo_full_i=1.
REQ-027 SHALL sustain one word per P_RATIO accepted beats with no bubble when fifo_full_i=0 (back-to-back words).
REQ-028 SHALL increment word_cnt_o per counted FIFO write and frame_cnt_o per accepted in_last_i beat; both wrap 2^32-1 -> 0.
REQ-029 SHALL make in_last_i on lane P_RATIO-1 produce exactly one word.
REQ-030 SHALL make flush_i coincident with a completing beat produce exactly one word.

Reset
REQ-031 SHALL, on wr_rst_n_i=0 at any time, asynchronously clear lane_cnt, accumulator, output register, out_pend, word_cnt_o and frame_cnt_o.
REQ-032 SHALL hold in_ready_o=1, fifo_en_o=0 and fifo_data_o=0 under reset.
REQ-033 SHALL discard any partial word or pending output on reset mid-operation, with no FIFO write after release.

Verification
REQ-034 SHALL verify (D_WIDTH=8, P_RATIO=4) beats 11,22,33,44 back-to-back with fifo_full_i=0 -> one cycle after 44: fifo_en_o=1 for 1 cycle, fifo_data_o=0x44332211, word_cnt_o=1.
REQ-035 SHALL verify beats AA,BB with in_last_i on BB -> fifo_data_o=0x0000BBAA, frame_cnt_o=1, lane_cnt=0.
REQ-036 SHALL verify word pending with fifo_full_i=1 for 5 cycles -> fifo_en_o/fifo_data_o held, in_ready_o=0, word_cnt_o unchanged; fifo_full_i=0 -> one write, word_cnt_o +1.
REQ-037 SHALL verify beat 55 then flush_i=1 -> fifo_data_o=0x00000055; flush_i alone on empty accumulator -> no fifo_en_o.
REQ-038 SHALL verify 16 beats streamed continuously with fifo_full_i=0 -> 4 words on consecutive writes with no in_ready_o deassertion.
REQ-039 SHALL verify reset asserted after 2 beats -> no write after release; next 4 beats 01..04 -> fifo_data_o=0x04030201.
